dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter sharing the single-port 32x32 data memory between the core load/store unit and a DMA/debug port. Accepts at most one request per cycle via valid/ready handshakes, drives the memory's write-enable/address/write-data, and returns read data or write acknowledge on a registered response channel one cycle after acceptance. Sits between the requesters and the data memory; bad addresses are rejected here and never reach the array.

## Interface
- `DEPTH`, default 32: memory words; must be a power of two.
- `DATA_W`, default 32: data width.
- `CLK` in 1: clock, all state updates on rising edge.
- `RST` in 1: synchronous, active-low reset.
- `c_req_valid` / `c_req_ready` in/out 1: core request handshake.
- `c_req_we` in 1: 1 = store, 0 = load.
- `c_req_addr` in 32: byte address.
- `c_req_wdata` in DATA_W: store data.
- `c_rsp_valid` / `c_rsp_ready` out/in 1: core response handshake.
- `c_rsp_rdata` out DATA_W: load data; 0 for stores and errors.
- `c_rsp_err` out 1: misaligned or out-of-range request.
- `d_*` ports: identical set for the DMA requester.
- `mem_we` out 1: memory write enable.
- `mem_a` out 32: word index, zero-extended.
- `mem_wd` out DATA_W: memory write data.
- `mem_rd` in DATA_W: memory read data, combinational from `mem_a`.

## Operation
- Per-requester FSM, two states: IDLE (no response owed), RSP (response valid, awaiting `rsp_ready`).
- Eligible: `req_valid` and (IDLE, or RSP with `rsp_ready` high this cycle).
- `req_ready` is high only for the single granted eligible requester; a request transfers when valid and ready are both high.
- Conflict when both are eligible: resolved by the arbitration policy (see Configuration). A lone eligible requester always wins.
- On accept with a valid address:
  - `mem_a = addr[log2(DEPTH)+1:2]`.
  - `mem_we = we`; `mem_wd = wdata`.
  - Load data `mem_rd` is registered into that requester's `rsp_rdata`.
- Address check:
  - Error when `addr[1:0] != 0` or `addr[31:log2(DEPTH)+2] != 0`.
  - On error: `mem_we` forced 0, response has `err=1`, `rdata=0`. The request still consumes the grant slot.
- With no accept: `mem_we=0`, `mem_a=0`, `mem_wd=0`.
- Accept transitions that requester to RSP. `rsp_ready` with no new accept returns it to IDLE. Back-to-back accept plus rsp handshake stays in RSP with new data.

## Timing
- Request accepted at edge N: write committed at edge N; `rsp_valid`, `rdata` and `err` are valid after edge N.
- Throughput is 1 access/cycle aggregate. A requester sustains 1/cycle while holding `rsp_ready` high.
- Response outputs are held stable while `rsp_valid && !rsp_ready`.
- `req_ready` and `mem_*` are combinational from `req_valid`, `rsp_ready`, FSM state and the RR pointer.
- Reset while `RST=0`, including mid-operation:
  - both FSMs return to IDLE; all `rsp_valid`, `rsp_err` and `rsp_rdata` are 0;
  - `req_ready=0`, `mem_we=0`;
  - RR pointer = "DMA last", so the core wins the first tie.
  - Pending responses are dropped.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin.
  - On a conflict, the requester not granted last wins.
  - The pointer updates on every accept.
- `DMEM_ARB_RR_EN` not defined: fixed priority, core always wins conflicts.
  - No pointer register exists.
  - DMA can starve under continuous core traffic.

## Structure
- Shared package `dmem_pkg`:
  - constants `DMEM_DEPTH=32`, `DMEM_IDX_W=5`;
  - enum `rsp_state_t {RSP_IDLE, RSP_PEND}`;
  - requester id constants `REQ_CORE=0`, `REQ_DMA=1`.
- Sub-module `dmem_rsp_slot`, instantiated twice: one per-requester FSM plus its response registers (`valid`, `rdata`, `err`) and eligibility output.
- Top level holds the grant logic, the address checker and the memory mux.

## Test plan
- Reset check: RST=0 for 2 cycles with both `req_valid=1` -> `req_ready=0`, `mem_we=0`, `rsp_valid=0`. After release the core is granted first.
- Core store then load: store `addr=0x10`, `wdata=0xDEADBEEF` -> `mem_we=1`, `mem_a=4`, ack with `err=0`. Load `0x10` next cycle -> `c_rsp_rdata=0xDEADBEEF` one cycle later.
- Conflict with RR enabled: both valid for 4 cycles, `rsp_ready=1` -> grants alternate C, D, C, D. With the macro undefined -> C, C, C, C.
- Backpressure: `c_rsp_ready=0` after a core load -> response held stable and `c_req_ready=0`. The DMA is still granted meanwhile; raising `c_rsp_ready` lets the core be re-accepted the same cycle.
- Bad address: core load `0x13`, then DMA store `0x80` -> both respond `err=1`, `rdata=0`, `mem_we` never asserted; memory contents unchanged.
- Reset mid-response: `c_rsp_valid=1` pending, assert RST -> `c_rsp_valid=0` next cycle. No stale response appears after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants, types and address-check helper for the data-memory arbiter.
package dmem_pkg;

  localparam int   DMEM_DEPTH = 32;
  localparam int   DMEM_IDX_W = 5;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  typedef enum logic {
    RSP_IDLE,
    RSP_PEND
  } rsp_state_t;

  // A request is bad when it is not word aligned or addresses past the array.
  function automatic logic addr_bad(input logic [31:0] addr, input int idx_w);
    logic [31:0] hi;
    hi = addr >> (idx_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's request/response channel; master = requester, slave = arbiter.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_rsp_slot.sv
// Per-requester response FSM: holds the registered response until it is taken
// and reports whether the requester may issue a new request this cycle.
module dmem_rsp_slot
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic              rsp_ready,
  input  logic              accept,
  input  logic              err_in,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              eligible,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata
);

  rsp_state_t        state_reg;
  logic              valid_reg;
  logic              err_reg;
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= RSP_IDLE;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        RSP_IDLE: begin
          if (accept) begin
            state_reg <= RSP_PEND;
            valid_reg <= 1'b1;
            err_reg   <= err_in;
            rdata_reg <= rdata_in;
          end
        end
        RSP_PEND: begin
          // A new accept can only happen alongside the rsp handshake.
          if (accept) begin
            err_reg   <= err_in;
            rdata_reg <= rdata_in;
          end else if (rsp_ready) begin
            state_reg <= RSP_IDLE;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= RSP_IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign eligible  = req_valid && ((state_reg == RSP_IDLE) || rsp_ready);
  assign rsp_valid = valid_reg;
  assign rsp_err   = err_reg;
  assign rsp_rdata = rdata_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Core / DMA arbiter in front of the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin on conflicts; otherwise the core has fixed priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  dmem_arbiter_if.slave     c,
  dmem_arbiter_if.slave     d,
  output logic              mem_we,
  output logic [31:0]       mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]        req_valid;
  logic [1:0]        req_we;
  logic [31:0]       req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [1:0]        rsp_ready;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_err;
  logic [DATA_W-1:0] rsp_rdata [2];

  logic              core_wins_tie;
  logic              any_grant;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_err;
  logic [DATA_W-1:0] rdata_in;

  assign req_valid[REQ_CORE] = c.req_valid;
  assign req_we[REQ_CORE]    = c.req_we;
  assign req_addr[REQ_CORE]  = c.req_addr;
  assign req_wdata[REQ_CORE] = c.req_wdata;
  assign rsp_ready[REQ_CORE] = c.rsp_ready;

  assign req_valid[REQ_DMA]  = d.req_valid;
  assign req_we[REQ_DMA]     = d.req_we;
  assign req_addr[REQ_DMA]   = d.req_addr;
  assign req_wdata[REQ_DMA]  = d.req_wdata;
  assign rsp_ready[REQ_DMA]  = d.rsp_ready;

`ifdef DMEM_ARB_RR_EN
  logic last_dma_reg;

  // Reset as if the DMA went last so the core takes the first tie.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      last_dma_reg <= 1'b1;
    end else if (any_grant) begin
      last_dma_reg <= grant[REQ_DMA];
    end
  end

  assign core_wins_tie = last_dma_reg;
`else
  assign core_wins_tie = 1'b1;
`endif

  assign grant[REQ_CORE] = RST && eligible[REQ_CORE] && (!eligible[REQ_DMA] || core_wins_tie);
  assign grant[REQ_DMA]  = RST && eligible[REQ_DMA] && !grant[REQ_CORE];
  assign any_grant       = |grant;

  assign c.req_ready = grant[REQ_CORE];
  assign d.req_ready = grant[REQ_DMA];

  assign sel_we    = grant[REQ_DMA] ? req_we[REQ_DMA]    : req_we[REQ_CORE];
  assign sel_addr  = grant[REQ_DMA] ? req_addr[REQ_DMA]  : req_addr[REQ_CORE];
  assign sel_wdata = grant[REQ_DMA] ? req_wdata[REQ_DMA] : req_wdata[REQ_CORE];
  assign addr_err  = addr_bad(sel_addr, IDX_W);

  // Rejected requests never reach the array: the whole memory bus stays idle.
  always_comb begin
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_wd   = '0;
    rdata_in = '0;
    if (any_grant && !addr_err) begin
      mem_we = sel_we;
      mem_a  = {{(32 - IDX_W){1'b0}}, sel_addr[IDX_W+1:2]};
      mem_wd = sel_wdata;
      if (!sel_we) begin
        rdata_in = mem_rd;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      dmem_rsp_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid[gi]),
        .rsp_ready (rsp_ready[gi]),
        .accept    (grant[gi]),
        .err_in    (addr_err),
        .rdata_in  (rdata_in),
        .eligible  (eligible[gi]),
        .rsp_valid (rsp_valid[gi]),
        .rsp_err   (rsp_err[gi]),
        .rsp_rdata (rsp_rdata[gi])
      );
    end
  endgenerate

  assign c.rsp_valid = rsp_valid[REQ_CORE];
  assign c.rsp_err   = rsp_err[REQ_CORE];
  assign c.rsp_rdata = rsp_rdata[REQ_CORE];
  assign d.rsp_valid = rsp_valid[REQ_DMA];
  assign d.rsp_err   = rsp_err[REQ_DMA];
  assign d.rsp_rdata = rsp_rdata[REQ_DMA];

endmodule
